// File: rtl/pulse_window_counter.sv
// Counts detector pulses over back-to-back programmable windows and hands each
// window's count downstream through a single-entry valid/ready result slot.
module pulse_window_counter #(
    parameter int CNT_W = 8,
    parameter int WIN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIN_W-1:0] win_len,
    input  logic             pulse_in,
    output logic [CNT_W-1:0] cnt_out,
    output logic             cnt_sat,
    output logic             cnt_valid,
    input  logic             cnt_ready,
    output logic             drop,
    output logic             busy,
    output logic             dbg_state
);

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] ACC_MAX = '1;
    localparam logic [CNT_W-1:0] ACC_ONE = 1;
    localparam logic [WIN_W-1:0] WIN_ONE = 1;

    state_t           state_q, state_d;
    logic [WIN_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] acc_q, acc_d;
    logic             sat_acc_q, sat_acc_d;
    logic [CNT_W-1:0] cnt_out_q, cnt_out_d;
    logic             cnt_sat_q, cnt_sat_d;
    logic             cnt_valid_q, cnt_valid_d;
    logic             drop_q, drop_d;

    logic [WIN_W-1:0] win_last;
    logic [CNT_W-1:0] acc_step;
    logic             sat_step;
    logic             win_end;
    logic             accept;
    logic             slot_free;

    // rem holds cycles left after the current one, so a zero length is a one-cycle window.
    assign win_last = (win_len == '0) ? '0 : (win_len - WIN_ONE);

    always_comb begin
        acc_step = acc_q;
        sat_step = sat_acc_q;
        if (pulse_in) begin
            if (acc_q == ACC_MAX) begin
                sat_step = 1'b1;
            end else begin
                acc_step = acc_q + ACC_ONE;
            end
        end
    end

    // Handshake: a result transfers on any cycle where cnt_valid && cnt_ready.
    // While cnt_valid is high, cnt_out/cnt_sat never change unless that same
    // cycle transfers and a new window ends, in which case the new result
    // loads and cnt_valid stays high with no gap.
    assign win_end   = (state_q == COUNT) && (rem_q == '0);
    assign accept    = cnt_valid_q && cnt_ready;
    assign slot_free = !cnt_valid_q || accept;

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        acc_d     = acc_q;
        sat_acc_d = sat_acc_q;
        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d   = COUNT;
                    rem_d     = win_last;
                    acc_d     = '0;
                    sat_acc_d = 1'b0;
                end
            end
            COUNT: begin
                if (rem_q == '0) begin
                    acc_d     = '0;
                    sat_acc_d = 1'b0;
                    if (en) begin
                        rem_d = win_last;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    rem_d     = rem_q - WIN_ONE;
                    acc_d     = acc_step;
                    sat_acc_d = sat_step;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        cnt_out_d   = cnt_out_q;
        cnt_sat_d   = cnt_sat_q;
        cnt_valid_d = cnt_valid_q;
        drop_d      = 1'b0;
        if (win_end) begin
            if (slot_free) begin
                cnt_out_d   = acc_step;
                cnt_sat_d   = sat_step;
                cnt_valid_d = 1'b1;
            end else begin
                drop_d = 1'b1;
            end
        end else if (accept) begin
            cnt_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            acc_q       <= '0;
            sat_acc_q   <= 1'b0;
            cnt_out_q   <= '0;
            cnt_sat_q   <= 1'b0;
            cnt_valid_q <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            acc_q       <= acc_d;
            sat_acc_q   <= sat_acc_d;
            cnt_out_q   <= cnt_out_d;
            cnt_sat_q   <= cnt_sat_d;
            cnt_valid_q <= cnt_valid_d;
            drop_q      <= drop_d;
        end
    end

    assign cnt_out   = cnt_out_q;
    assign cnt_sat   = cnt_sat_q;
    assign cnt_valid = cnt_valid_q;
    assign drop      = drop_q;
    assign busy      = (state_q == COUNT);
    assign dbg_state = state_q;

endmodule
